// File: rtl/rf_ctrl_pkg.sv
// Shared constants and types for the register-file control slice.
// The writeback arbiter defaults its parameters from these values.
package rf_ctrl_pkg;

    localparam int RF_NREG     = 32;
    localparam int RF_AW       = 5;
    localparam int RF_DW       = 32;
    localparam int RF_NREQ_DEF = 3;

    typedef logic [RF_AW-1:0] rf_addr_t;
    typedef logic [RF_DW-1:0] rf_data_t;

endpackage : rf_ctrl_pkg

// File: rtl/rf_write_arbiter_rr.sv
// Combinational round-robin arbiter.
// Picks the first asserted request starting at ptr_i and wrapping modulo NREQ.
// Returns a one-hot grant and the binary index of the winner.
// When no request is asserted, the grant is all zeros and the index is zero.
module rr_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int NREQ = RF_NREQ_DEF,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [PW-1:0]   grant_idx_o
);

    logic found;
    int   idx;

    // Scan the requests in rotated order and keep the first asserted one.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = PW'(idx);
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter that shares the register file's single write port
// among NREQ writeback requesters, using a valid/ready handshake on each one.
// The winning request is captured into a one-entry output register.
// That register drives A3/WD/WE directly.
// Writes to register 0 are accepted but never raise WE.
// Optional feature macro: RF_WARB_PERF_EN.
// When it is defined, conflict_cnt is a saturating count of cycles
// in which two or more requesters were valid.
module rf_write_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int NREQ = RF_NREQ_DEF,
    parameter int n    = RF_AW,
    parameter int m    = RF_DW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*n-1:0] req_addr,
    input  logic [NREQ*m-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [n-1:0]      A3,
    output logic [m-1:0]      WD,
    output logic              WE,
    output logic [31:0]       conflict_cnt
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [n-1:0]    a3_q, a3_d;
    logic [m-1:0]    wd_q, wd_d;
    logic            we_q, we_d;
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   grant_idx;
    logic            transfer;
    logic [n-1:0]    sel_addr;
    logic [m-1:0]    sel_data;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    // The output stage always accepts.
    // Any grant is therefore a transfer, and ready is masked while reset is held.
    assign req_ready = grant & {NREQ{rst_n}};
    assign transfer  = |grant;
    assign sel_addr  = req_addr[grant_idx*n +: n];
    assign sel_data  = req_data[grant_idx*m +: m];

    // Next pointer and output register contents.
    // Address 0 loads A3/WD but keeps WE low, so r0 is never written.
    always_comb begin
        ptr_d = ptr_q;
        a3_d  = a3_q;
        wd_d  = wd_q;
        we_d  = 1'b0;
        if (transfer) begin
            a3_d = sel_addr;
            wd_d = sel_data;
            we_d = (sel_addr != '0);
            if (grant_idx == PW'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + PW'(1);
            end
        end
    end

    // Priority pointer and write-port register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            a3_q  <= '0;
            wd_q  <= '0;
            we_q  <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            a3_q  <= a3_d;
            wd_q  <= wd_d;
            we_q  <= we_d;
        end
    end

    assign A3 = a3_q;
    assign WD = wd_q;
    assign WE = we_q;

`ifdef RF_WARB_PERF_EN
    logic [31:0] conflict_q, conflict_d;

    // Count contended cycles, holding at the maximum value instead of wrapping.
    always_comb begin
        conflict_d = conflict_q;
        if (($countones(req_valid) >= 2) && (conflict_q != 32'hFFFF_FFFF)) begin
            conflict_d = conflict_q + 32'd1;
        end
    end

    // Contention counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= '0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = 32'd0;
`endif

endmodule : rf_write_arbiter

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter with its default parameters.
// Build it with RF_WARB_PERF_EN defined to expect a live contention counter.
module tb_rf_write_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic [AW-1:0]       A3;
    logic [DW-1:0]       WD;
    logic                WE;
    logic [31:0]         conflict_cnt;

    int totalCount = 0;
    int badCount   = 0;

    logic [DW-1:0] rfModel [32];

    typedef struct {
        logic [2:0]  valid;
        logic [14:0] addr;
        logic [95:0] data;
        logic [2:0]  expReady;
        logic        expWe;
        logic [4:0]  expA3;
        logic [31:0] expWd;
    } vec_t;

    vec_t vecs[$];

    rf_write_arbiter #(
        .NREQ (NREQ),
        .n    (AW),
        .m    (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .A3           (A3),
        .WD           (WD),
        .WE           (WE),
        .conflict_cnt (conflict_cnt)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Simple register file fed from the write port; it has no hardwired zero.
    always @(posedge clk) begin
        if (WE) rfModel[A3] <= WD;
    end

    function automatic vec_t mkVec(logic [2:0] v, logic [14:0] a, logic [95:0] d,
                                   logic [2:0] r, logic we, logic [4:0] a3, logic [31:0] wd);
        vec_t t;
        t.valid = v; t.addr = a; t.data = d;
        t.expReady = r; t.expWe = we; t.expA3 = a3; t.expWd = wd;
        return t;
    endfunction

    task automatic applyStimulus(input vec_t t);
        req_valid = t.valid;
        req_addr  = t.addr;
        req_data  = t.data;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act !== exp) begin
            badCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] expConflict;
`ifdef RF_WARB_PERF_EN
        expConflict = 32'd4;
`else
        expConflict = 32'd0;
`endif
        for (int i = 0; i < 32; i++) rfModel[i] = '0;

        // Vector table: inputs for one cycle, ready in that cycle, and port state after the edge.
        vecs.push_back(mkVec(3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEAD_BEEF, 32'h0}, 3'b010, 1'b1, 5'd5, 32'hDEAD_BEEF));
        vecs.push_back(mkVec(3'b000, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEAD_BEEF, 32'h0}, 3'b000, 1'b0, 5'd5, 32'hDEAD_BEEF));
        vecs.push_back(mkVec(3'b100, {5'd7, 5'd0, 5'd0}, {32'h77, 32'h0, 32'h0}, 3'b100, 1'b1, 5'd7, 32'h77));
        vecs.push_back(mkVec(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 3'b001, 1'b1, 5'd1, 32'h11));
        vecs.push_back(mkVec(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 3'b010, 1'b1, 5'd2, 32'h22));
        vecs.push_back(mkVec(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 3'b100, 1'b1, 5'd3, 32'h33));
        vecs.push_back(mkVec(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 3'b001, 1'b1, 5'd1, 32'h11));
        vecs.push_back(mkVec(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 3'b010, 1'b1, 5'd2, 32'h22));
        vecs.push_back(mkVec(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 3'b100, 1'b1, 5'd3, 32'h33));
        vecs.push_back(mkVec(3'b001, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h1234}, 3'b001, 1'b0, 5'd0, 32'h1234));
        vecs.push_back(mkVec(3'b000, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h0}, 3'b000, 1'b0, 5'd0, 32'h1234));
        vecs.push_back(mkVec(3'b101, {5'd9, 5'd0, 5'd8}, {32'h99, 32'h0, 32'h88}, 3'b100, 1'b1, 5'd9, 32'h99));
        vecs.push_back(mkVec(3'b101, {5'd9, 5'd0, 5'd8}, {32'h99, 32'h0, 32'h88}, 3'b001, 1'b1, 5'd8, 32'h88));
        vecs.push_back(mkVec(3'b000, {5'd9, 5'd0, 5'd8}, {32'h99, 32'h0, 32'h88}, 3'b000, 1'b0, 5'd8, 32'h88));

        // Reset held with requests present: ready is masked and the port is cleared.
        rst_n     = 1'b0;
        req_valid = 3'b111;
        req_addr  = {5'd3, 5'd2, 5'd1};
        req_data  = {32'h33, 32'h22, 32'h11};
        #12;
        checkOutput("reset_ready", 32'(req_ready), 32'd0);
        checkOutput("reset_we", 32'(WE), 32'd0);
        checkOutput("reset_a3", 32'(A3), 32'd0);
        checkOutput("reset_wd", WD, 32'd0);
        checkOutput("reset_conflict", conflict_cnt, 32'd0);

        // Release reset with no requests and watch ten idle cycles.
        @(negedge clk);
        req_valid = 3'b000;
        rst_n     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput("idle_we", 32'(WE), 32'd0);
            checkOutput("idle_a3", 32'(A3), 32'd0);
            checkOutput("idle_wd", WD, 32'd0);
            checkOutput("idle_ready", 32'(req_ready), 32'd0);
        end

        // Table-driven vectors: single requester, rotation, r0 drop, withdraw and wrap.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].expReady));
            @(posedge clk); #1;
            checkOutput($sformatf("v%0d_we", i), 32'(WE), 32'(vecs[i].expWe));
            checkOutput($sformatf("v%0d_a3", i), 32'(A3), 32'(vecs[i].expA3));
            checkOutput($sformatf("v%0d_wd", i), WD, vecs[i].expWd);
        end
        @(posedge clk); #1;
        checkOutput("rf_r0", rfModel[0], 32'd0);
        checkOutput("rf_r5", rfModel[5], 32'hDEAD_BEEF);

        // Mid-stream reset: the pointer is at 1, so requester 1 wins and WE goes high.
        @(negedge clk);
        req_valid = 3'b111;
        req_addr  = {5'd3, 5'd2, 5'd1};
        req_data  = {32'h33, 32'h22, 32'h11};
        @(posedge clk); #1;
        checkOutput("pre_rst_we", 32'(WE), 32'd1);
        checkOutput("pre_rst_a3", 32'(A3), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_we", 32'(WE), 32'd0);
        checkOutput("async_rst_a3", 32'(A3), 32'd0);
        checkOutput("async_rst_wd", WD, 32'd0);
        checkOutput("async_rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_ready", 32'(req_ready), 32'b001);
        @(posedge clk); #1;
        checkOutput("post_rst_a3", 32'(A3), 32'd1);
        checkOutput("post_rst_we", 32'(WE), 32'd1);

        // Contention counter: clear it, then hold requesters 0 and 2 valid for four edges.
        @(negedge clk);
        req_valid = 3'b000;
        rst_n     = 1'b0;
        #1;
        checkOutput("cnt_cleared", conflict_cnt, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 3'b101;
        repeat (4) @(posedge clk);
        @(negedge clk);
        req_valid = 3'b000;
        #1;
        checkOutput("conflict_cnt", conflict_cnt, expConflict);
        @(posedge clk); #1;
        checkOutput("conflict_hold", conflict_cnt, expConflict);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule : tb_rf_write_arbiter
